// File: rtl/interpolator.sv
// Linear interpolator: ramps from the previous low-rate sample to the
// current one over R = 2^LOG2_R clocks, one output per clock.
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous reset, active high
//   data_in   low-rate unsigned sample
//   new_data  single-cycle strobe, data_in valid
//   ready     holding register empty
//   data_out  interpolated sample (registered)
//   out_valid data_out valid, high every cycle once running
//   underrun  sticky: a period ended with no next sample
//   overrun   sticky: a sample was dropped, holding register full
module interpolator #(
   parameter int DATA_W = 12,
   parameter int LOG2_R = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              new_data,
   output logic              ready,
   output logic [DATA_W-1:0] data_out,
   output logic              out_valid,
   output logic              underrun,
   output logic              overrun
);

   localparam int ACC_W = DATA_W + LOG2_R + 1;

   typedef enum logic [1:0] {
      S_EMPTY,
      S_PRIME,
      S_RUN
   } state_t;

   state_t state, state_nxt;

   logic [DATA_W-1:0]        prev;
   logic [DATA_W-1:0]        cur;
   logic [DATA_W-1:0]        hold;
   logic                     hold_full;
   logic signed [DATA_W:0]   delta;
   logic signed [ACC_W-1:0]  acc;
   logic [LOG2_R-1:0]        phase;

   logic                     running;
   logic                     period_end;
   logic                     take_hold;
   logic                     bypass;
   logic                     capture;
   logic                     refill;
   logic                     drop;
   logic [DATA_W-1:0]        next_cur;
   logic signed [ACC_W-1:0]  delta_ext;

   function automatic logic signed [DATA_W:0] diff(
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b
   );
      return $signed({1'b0, a}) - $signed({1'b0, b});
   endfunction

   // Sample placed on the integer part of the accumulator.
   function automatic logic signed [ACC_W-1:0] scale(
      input logic [DATA_W-1:0] v
   );
      return {1'b0, v, {LOG2_R{1'b0}}};
   endfunction

   assign ready      = !hold_full;
   assign running    = (state == S_RUN);
   assign period_end = running && (phase == {LOG2_R{1'b1}});
   assign take_hold  = period_end && hold_full;
   assign bypass     = period_end && !hold_full && new_data;
   assign capture    = running && new_data && !hold_full && !period_end;
   assign refill     = take_hold && new_data;
   assign drop       = running && new_data && hold_full && !period_end;
   assign delta_ext  = {{LOG2_R{delta[DATA_W]}}, delta};

   // With no next sample, next_cur == cur and the new delta is zero,
   // so the output holds flat until a sample arrives.
   always_comb begin
      next_cur = cur;
      if (take_hold) begin
         next_cur = hold;
      end else if (bypass) begin
         next_cur = data_in;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_EMPTY: if (new_data) state_nxt = S_PRIME;
         S_PRIME: if (new_data) state_nxt = S_RUN;
         S_RUN:   state_nxt = S_RUN;
         default: state_nxt = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev      <= '0;
         cur       <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         delta     <= '0;
         acc       <= '0;
         phase     <= '0;
         data_out  <= '0;
         out_valid <= 1'b0;
         underrun  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         unique case (state)
            S_EMPTY: begin
               out_valid <= 1'b0;
               if (new_data) prev <= data_in;
            end
            S_PRIME: begin
               out_valid <= 1'b0;
               if (new_data) begin
                  cur   <= data_in;
                  delta <= diff(data_in, prev);
                  acc   <= scale(prev);
                  phase <= '0;
               end
            end
            S_RUN: begin
               data_out  <= acc[LOG2_R+DATA_W-1:LOG2_R];
               out_valid <= 1'b1;
               phase     <= phase + LOG2_R'(1);
               if (period_end) begin
                  // Exact reload at each period start: no drift.
                  prev  <= cur;
                  acc   <= scale(cur);
                  cur   <= next_cur;
                  delta <= diff(next_cur, cur);
                  if (!take_hold && !bypass) underrun <= 1'b1;
               end else begin
                  acc <= acc + delta_ext;
               end
               if (capture || refill) hold <= data_in;
               if (capture) begin
                  hold_full <= 1'b1;
               end else if (take_hold && !new_data) begin
                  hold_full <= 1'b0;
               end
               if (drop) overrun <= 1'b1;
            end
            default: out_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_interpolator.sv
// Self-checking bench for interpolator: table of ramp spot checks
// plus directed sequences for cadence, underrun, overrun and reset.
module tb_interpolator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] data_in = '0;
   logic        new_data = 1'b0;
   logic        ready;
   logic [11:0] data_out;
   logic        out_valid;
   logic        underrun;
   logic        overrun;

   int total = 0;
   int bad   = 0;

   interpolator #(.DATA_W(12), .LOG2_R(9)) dut (
      .clk      (clk),
      .rst      (rst),
      .data_in  (data_in),
      .new_data (new_data),
      .ready    (ready),
      .data_out (data_out),
      .out_valid(out_valid),
      .underrun (underrun),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int a;
      int b;
      int e0;
      int e1;
      int e256;
      int e511;
      int enx;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input int v);
      new_data = 1'b1;
      data_in  = 12'(v);
      step();
      new_data = 1'b0;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      new_data = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, " data_out"}, 32'(data_out), 0);
      chk({nm, " out_valid"}, 32'(out_valid), 0);
      chk({nm, " ready"}, 32'(ready), 1);
      chk({nm, " underrun"}, 32'(underrun), 0);
      chk({nm, " overrun"}, 32'(overrun), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      // a, b, phase0, phase1, phase256, phase511, next start
      tbl[0] = '{100, 612, 100, 101, 356, 611, 612};
      tbl[1] = '{4000, 3999, 4000, 3999, 3999, 3999, 3999};
      tbl[2] = '{0, 4095, 0, 7, 2047, 4087, 4095};
      tbl[3] = '{4095, 0, 4095, 4087, 2047, 7, 0};
      tbl[4] = '{1000, 1000, 1000, 1000, 1000, 1000, 1000};
      tbl[5] = '{10, 13, 10, 10, 11, 12, 13};

      // Reset with strobes present.
      rst      = 1'b1;
      new_data = 1'b1;
      data_in  = 12'd55;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_idle("reset");
      end
      rst      = 1'b0;
      new_data = 1'b0;
      step();
      chk_idle("post reset");

      // Table of single-period ramps.
      for (int r = 0; r < 6; r++) begin
         do_reset();
         strobe(tbl[r].a);
         strobe(tbl[r].b);
         chk("tbl prime valid", 32'(out_valid), 0);
         for (int k = 0; k < 512; k++) begin
            new_data = (k == 100);
            data_in  = 12'(tbl[r].b);
            step();
            new_data = 1'b0;
            if (k == 0)   chk("tbl p0", 32'(data_out), 32'(tbl[r].e0));
            if (k == 0)   chk("tbl valid", 32'(out_valid), 1);
            if (k == 1)   chk("tbl p1", 32'(data_out), 32'(tbl[r].e1));
            if (k == 256) chk("tbl p256", 32'(data_out), 32'(tbl[r].e256));
            if (k == 511) chk("tbl p511", 32'(data_out), 32'(tbl[r].e511));
         end
         step();
         chk("tbl next", 32'(data_out), 32'(tbl[r].enx));
         chk("tbl underrun", 32'(underrun), 0);
         chk("tbl overrun", 32'(overrun), 0);
      end

      // Decimator cadence: strobes land on phase 511 (bypass path).
      do_reset();
      strobe(0);
      repeat (511) step();
      strobe(512);
      chk("cad prime valid", 32'(out_valid), 0);
      for (int i = 0; i < 3584; i++) begin
         new_data = (i % 512 == 511) && (i <= 3071);
         data_in  = 12'(512 * ((i + 1) / 512 + 1));
         step();
         new_data = 1'b0;
         chk("cad ramp", 32'(data_out), 32'(i));
         if (i == 3582) begin
            chk("cad underrun", 32'(underrun), 0);
            chk("cad overrun", 32'(overrun), 0);
         end
      end

      // Underrun, flat hold, then resume from hold.
      do_reset();
      strobe(0);
      strobe(512);
      for (int i = 0; i < 2304; i++) begin
         new_data = (i == 511) || (i == 1700);
         data_in  = (i == 511) ? 12'd1024 : 12'd1536;
         step();
         new_data = 1'b0;
         if (i == 1022) chk("und before", 32'(underrun), 0);
         if (i == 1023) chk("und set", 32'(underrun), 1);
         if (i >= 1024 && i <= 2048) chk("und flat", 32'(data_out), 1024);
         if (i == 1700) chk("und hold ready", 32'(ready), 0);
         if (i == 2047) chk("und consume ready", 32'(ready), 1);
         if (i == 2049) chk("und resume", 32'(data_out), 1025);
         if (i == 2303) chk("und ramp", 32'(data_out), 1279);
      end
      chk("und sticky", 32'(underrun), 1);

      // Hold consumed and refilled in the same cycle.
      do_reset();
      strobe(0);
      strobe(512);
      for (int i = 0; i < 1026; i++) begin
         new_data = (i == 5) || (i == 511);
         data_in  = (i == 5) ? 12'd1024 : 12'd2048;
         step();
         new_data = 1'b0;
         if (i == 511) chk("sim overrun", 32'(overrun), 0);
         if (i == 511) chk("sim ready", 32'(ready), 0);
         if (i == 512) chk("sim p0", 32'(data_out), 512);
         if (i == 513) chk("sim p1", 32'(data_out), 513);
         if (i == 1023) chk("sim ready2", 32'(ready), 1);
         if (i == 1024) chk("sim p0b", 32'(data_out), 1024);
         if (i == 1025) chk("sim p1b", 32'(data_out), 1026);
      end
      chk("sim overrun end", 32'(overrun), 0);
      chk("sim underrun end", 32'(underrun), 0);

      // Overrun, then reset mid-period.
      do_reset();
      strobe(0);
      strobe(1000);
      for (int i = 0; i < 600; i++) begin
         new_data = (i == 10) || (i == 20);
         data_in  = (i == 10) ? 12'd200 : 12'd300;
         step();
         new_data = 1'b0;
         if (i == 10) chk("ovr ready", 32'(ready), 0);
         if (i == 10) chk("ovr clear", 32'(overrun), 0);
         if (i == 20) chk("ovr set", 32'(overrun), 1);
         if (i == 511) chk("ovr ready2", 32'(ready), 1);
         if (i == 512) chk("ovr p0", 32'(data_out), 1000);
         if (i == 513) chk("ovr p1", 32'(data_out), 998);
      end
      chk("ovr sticky", 32'(overrun), 1);
      rst = 1'b1;
      step();
      chk_idle("mid reset");
      rst = 1'b0;
      strobe(77);
      chk("rst empty valid", 32'(out_valid), 0);
      strobe(88);
      chk("rst prime valid", 32'(out_valid), 0);
      step();
      chk("rst run valid", 32'(out_valid), 1);
      chk("rst run data", 32'(data_out), 77);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
